fetch_pc_unit: RTL



---
 rtl/fetch_pkg.sv | 43 ++++
 rtl/fetch_pc_unit_btb.sv | 68 ++++++
 rtl/fetch_pc_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types, constants and counter helpers for the fetch PC unit and its BTB.
package fetch_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bpu_cnt_t;

    // Tag field sized for the smallest legal table (2 entries); narrower tags are zero-extended.
    localparam int TAG_FIELD_W = 29;

    typedef struct packed {
        logic                   valid;
        logic [TAG_FIELD_W-1:0] tag;
        logic [31:0]            target;
        bpu_cnt_t               cnt;
    } btb_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic bpu_cnt_t cnt_inc(input bpu_cnt_t c);
        case (c)
            STRONG_NT: return WEAK_NT;
            WEAK_NT:   return WEAK_T;
            WEAK_T:    return STRONG_T;
            STRONG_T:  return STRONG_T;
            default:   return WEAK_NT;
        endcase
    endfunction

    function automatic bpu_cnt_t cnt_dec(input bpu_cnt_t c);
        case (c)
            STRONG_NT: return STRONG_NT;
            WEAK_NT:   return STRONG_NT;
            WEAK_T:    return WEAK_NT;
            STRONG_T:  return WEAK_T;
            default:   return WEAK_NT;
        endcase
    endfunction

endpackage

// File: rtl/fetch_pc_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous update/clear.
module branch_target_buffer
    import fetch_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic [31:2] iLookupPC,
    output logic        oPredTaken,
    output logic [31:0] oPredTarget,
    input  logic        iUpdate,
    input  logic [31:2] iUpdatePC,
    input  logic        iUpdateTaken,
    input  logic [31:0] iUpdateTarget
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    btb_entry_t r_btb [BTB_ENTRIES];

    logic [IDX_W-1:0]       w_lkp_idx;
    logic [TAG_FIELD_W-1:0] w_lkp_tag;
    btb_entry_t             w_lkp_entry;
    logic                   w_lkp_hit;

    logic [IDX_W-1:0]       w_upd_idx;
    logic [TAG_FIELD_W-1:0] w_upd_tag;
    btb_entry_t             w_upd_entry;
    logic                   w_upd_hit;

    assign w_lkp_idx   = iLookupPC[IDX_W+1:2];
    assign w_lkp_tag   = TAG_FIELD_W'(iLookupPC[31:IDX_W+2]);
    assign w_lkp_entry = r_btb[w_lkp_idx];
    assign w_lkp_hit   = w_lkp_entry.valid && (w_lkp_entry.tag == w_lkp_tag);
    assign oPredTaken  = w_lkp_hit && w_lkp_entry.cnt[1];
    assign oPredTarget = w_lkp_entry.target;

    assign w_upd_idx   = iUpdatePC[IDX_W+1:2];
    assign w_upd_tag   = TAG_FIELD_W'(iUpdatePC[31:IDX_W+2]);
    assign w_upd_entry = r_btb[w_upd_idx];
    assign w_upd_hit   = w_upd_entry.valid && (w_upd_entry.tag == w_upd_tag);

    // Table clear on reset; training or allocation on a resolved branch.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb[i].valid  <= 1'b0;
                r_btb[i].tag    <= '0;
                r_btb[i].target <= 32'h0000_0000;
                r_btb[i].cnt    <= WEAK_NT;
            end
        end else if (iUpdate) begin
            if (w_upd_hit) begin
                if (iUpdateTaken) begin
                    r_btb[w_upd_idx].cnt    <= cnt_inc(w_upd_entry.cnt);
                    r_btb[w_upd_idx].target <= iUpdateTarget;
                end else begin
                    r_btb[w_upd_idx].cnt    <= cnt_dec(w_upd_entry.cnt);
                end
            end else if (iUpdateTaken) begin
                r_btb[w_upd_idx] <= '{valid: 1'b1, tag: w_upd_tag,
                                      target: iUpdateTarget, cnt: WEAK_T};
            end
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator with BTB-based prediction.
// Optional FETCH_BPU_STATS_EN adds branch and mispredict event counters.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iStallF,
    input  logic        iRedirectE,
    input  logic [31:0] iRedirectPCE,
    input  logic        iUpdateE,
    input  logic [31:0] iUpdatePCE,
    input  logic        iUpdateTakenE,
    input  logic [31:0] iUpdateTargetE,
    input  logic [31:0] iInstrMemF,
    output logic [31:0] oPCF,
    output logic [31:0] oInstructionF,
    output logic        oTakeJBF
`ifdef FETCH_BPU_STATS_EN
    ,
    output logic [31:0] oBranchCntF,
    output logic [31:0] oMispredCntF
`endif
);

    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic        w_pred_taken;
    logic [31:0] w_pred_target;
    logic        w_unused_low_bits;

    // Low address bits of Execute-supplied PCs are architecturally zero.
    assign w_unused_low_bits = ^{iUpdatePCE[1:0], iRedirectPCE[1:0]};

    branch_target_buffer #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .iClk          (iClk),
        .iRstN         (iRstN),
        .iLookupPC     (r_pc[31:2]),
        .oPredTaken    (w_pred_taken),
        .oPredTarget   (w_pred_target),
        .iUpdate       (iUpdateE),
        .iUpdatePC     (iUpdatePCE[31:2]),
        .iUpdateTaken  (iUpdateTakenE),
        .iUpdateTarget (iUpdateTargetE)
    );

    assign oPCF          = r_pc;
    assign oInstructionF = iInstrMemF;
    assign oTakeJBF      = w_pred_taken;

    // Next-PC select: redirect beats stall, stall beats prediction.
    always_comb begin
        w_next_pc = r_pc;
        if (iRedirectE) begin
            w_next_pc = {iRedirectPCE[31:2], 2'b00};
        end else if (iStallF) begin
            w_next_pc = r_pc;
        end else if (w_pred_taken) begin
            w_next_pc = w_pred_target;
        end else begin
            w_next_pc = r_pc + PC_STEP;
        end
    end

    // PC register.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

`ifdef FETCH_BPU_STATS_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    // Event counters, free-running with natural 32-bit wrap.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_branch_cnt  <= 32'h0000_0000;
            r_mispred_cnt <= 32'h0000_0000;
        end else begin
            r_branch_cnt  <= r_branch_cnt + {31'd0, iUpdateE};
            r_mispred_cnt <= r_mispred_cnt + {31'd0, iRedirectE};
        end
    end

    assign oBranchCntF  = r_branch_cnt;
    assign oMispredCntF = r_mispred_cnt;
`endif

endmodule
